// File: rtl/conv3_pkg.sv
// Shared widths, types and a golden-sum helper for the conv3 3-tap convolution engine.
package conv3_pkg;

    localparam int DATA_W = 4;
    localparam int KERN_W = 4;
    localparam int RES_W  = 10;

    typedef logic [DATA_W-1:0] sample_t;
    typedef logic [KERN_W-1:0] kern_t;
    typedef logic [RES_W-1:0]  res_t;

    function automatic res_t conv3_ref(input kern_t k0, input kern_t k1, input kern_t k2,
                                       input sample_t d0, input sample_t d1, input sample_t d2);
        return res_t'(k0) * res_t'(d0) + res_t'(k1) * res_t'(d1) + res_t'(k2) * res_t'(d2);
    endfunction

endpackage

// File: rtl/conv3_window.sv
// Three-sample sliding window with a saturating fill counter; o_full marks three accepts since reset.
module conv3_window #(
    parameter int DATA_W = conv3_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_d0,
    output logic [DATA_W-1:0] o_d1,
    output logic [DATA_W-1:0] o_d2,
    output logic              o_full
);
    import conv3_pkg::*;

    logic [DATA_W-1:0] r_d0;
    logic [DATA_W-1:0] r_d1;
    logic [DATA_W-1:0] r_d2;
    logic [1:0]        r_fill;

    // Shift in a new sample on each strobe; idle cycles hold the window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d0   <= '0;
            r_d1   <= '0;
            r_d2   <= '0;
            r_fill <= 2'd0;
        end else if (i_en) begin
            r_d2 <= r_d1;
            r_d1 <= r_d0;
            r_d0 <= i_data;
            if (r_fill != 2'd3) begin
                r_fill <= r_fill + 2'd1;
            end
        end
    end

    assign o_d0   = r_d0;
    assign o_d1   = r_d1;
    assign o_d2   = r_d2;
    assign o_full = (r_fill == 2'd3);

endmodule

// File: rtl/conv3_mac.sv
// 3-tap convolution MAC: result = k0*d0 + k1*d1 + k2*d2 (d0 newest), registered output.
// Define CONV3_PIPE_EN to insert a product register stage (latency 2 instead of 1).
module conv3_mac #(
    parameter int DATA_W = conv3_pkg::DATA_W,
    parameter int KERN_W = conv3_pkg::KERN_W,
    parameter int RES_W  = conv3_pkg::RES_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              data_en,
    input  logic [DATA_W-1:0] data,
    input  logic [KERN_W-1:0] kernel_0,
    input  logic [KERN_W-1:0] kernel_1,
    input  logic [KERN_W-1:0] kernel_2,
    output logic [RES_W-1:0]  result,
    output logic              result_valid
);
    import conv3_pkg::*;

    if (RES_W < DATA_W + KERN_W + 2) begin : g_res_w_check
        $error("conv3_mac: RES_W must be >= DATA_W+KERN_W+2");
    end

    logic [DATA_W-1:0] w_d0;
    logic [DATA_W-1:0] w_d1;
    logic [DATA_W-1:0] w_d2;
    logic              w_full;
    logic [RES_W-1:0]  w_p0;
    logic [RES_W-1:0]  w_p1;
    logic [RES_W-1:0]  w_p2;
    logic [RES_W-1:0]  w_sum;
    logic              w_valid;
    logic              r_acc_q;
    logic [RES_W-1:0]  r_result;
    logic              r_valid;

    conv3_window #(.DATA_W(DATA_W)) u_window (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (data_en),
        .i_data (data),
        .o_d0   (w_d0),
        .o_d1   (w_d1),
        .o_d2   (w_d2),
        .o_full (w_full)
    );

    // Zero-extended products with live kernels; the result width leaves no room for overflow.
    always_comb begin
        w_p0 = RES_W'(kernel_0) * RES_W'(w_d0);
        w_p1 = RES_W'(kernel_1) * RES_W'(w_d1);
        w_p2 = RES_W'(kernel_2) * RES_W'(w_d2);
    end

`ifdef CONV3_PIPE_EN
    logic [RES_W-1:0] r_p0;
    logic [RES_W-1:0] r_p1;
    logic [RES_W-1:0] r_p2;
    logic             r_v1;

    // Product stage, with the valid flag carried alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p0 <= '0;
            r_p1 <= '0;
            r_p2 <= '0;
            r_v1 <= 1'b0;
        end else begin
            r_p0 <= w_p0;
            r_p1 <= w_p1;
            r_p2 <= w_p2;
            r_v1 <= r_acc_q && w_full;
        end
    end

    // Sum of the registered products.
    always_comb begin
        w_sum   = r_p0 + r_p1 + r_p2;
        w_valid = r_v1;
    end
`else
    // Single-stage sum straight from the window.
    always_comb begin
        w_sum   = w_p0 + w_p1 + w_p2;
        w_valid = r_acc_q && w_full;
    end
`endif

    // Output register; acc_q marks that the window just took a sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_q  <= 1'b0;
            r_result <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_acc_q  <= data_en;
            r_result <= w_sum;
            r_valid  <= w_valid;
        end
    end

    assign result       = r_result;
    assign result_valid = r_valid;

endmodule
